// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of cpu_mem's data port: port 0 is the cpu, port 1 the debug/loader master.
// One transaction in flight at a time, round-robin on ties, fixed read latency RD_LAT.
`timescale 1ns/1ps

package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    MEM_DT_BYTE  = 3'd0,
    MEM_DT_HALF  = 3'd1,
    MEM_DT_WORD  = 3'd2,
    MEM_DT_UBYTE = 3'd4,
    MEM_DT_UHALF = 3'd5
  } mem_dt_e;

  typedef enum logic [3:0] {
    ENONE     = 4'd0,
    EMISALIGN = 4'd1,
    EBADADDR  = 4'd2
  } errno_e;

endpackage

// Handshake: a requester raises reqN with we/addr/wd/dt stable and holds them
// until the one-cycle gntN pulse; the result arrives later as a one-cycle
// rvalidN pulse, with rdN/errN valid during it and held until the next
// completion for that port. There is no backpressure on the response side.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wd0,
  input  logic [31:0] wd1,
  input  mem_dt_e     dt0,
  input  mem_dt_e     dt1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output errno_e      err0,
  output errno_e      err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output mem_dt_e     mem_dt,
  input  logic [31:0] mem_rd,
  input  errno_e      mem_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [2:0] LAT = RD_LAT[2:0];

  logic [1:0]  state;
  logic        owner;
  logic        last_owner;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wd;
  mem_dt_e     lat_dt;
  logic [2:0]  cnt;
  logic        pick;
  logic [31:0] cap_rd;

  // On a tie the port that did not complete the previous transaction wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = ~last_owner;
    end
  end

  assign cap_rd    = lat_we ? 32'd0 : mem_rd;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      lat_addr   <= 32'd0;
      lat_wd     <= 32'd0;
      lat_dt     <= MEM_DT_WORD;
      cnt        <= 3'd0;
      rd0        <= 32'd0;
      rd1        <= 32'd0;
      err0       <= ENONE;
      err1       <= ENONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            lat_we   <= pick ? we1   : we0;
            lat_addr <= pick ? addr1 : addr0;
            lat_wd   <= pick ? wd1   : wd0;
            lat_dt   <= pick ? dt1   : dt0;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          cnt   <= LAT;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          // cnt==1 means this edge is the one where the count reaches zero.
          if (cnt == 3'd1) begin
            if (owner) begin
              rd1  <= cap_rd;
              err1 <= mem_err;
            end else begin
              rd0  <= cap_rd;
              err0 <= mem_err;
            end
            last_owner <= owner;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset idles them at once.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    mem_addr = 32'd0;
    mem_wd   = 32'd0;
    mem_we   = 1'b0;
    mem_dt   = MEM_DT_WORD;
    case (state)
      S_ACCESS: begin
        gnt0     = ~owner;
        gnt1     = owner;
        mem_addr = lat_addr;
        mem_wd   = lat_wd;
        mem_we   = lat_we;
        mem_dt   = lat_dt;
      end
      S_WAIT: begin
        mem_addr = lat_addr;
        mem_wd   = lat_wd;
        mem_dt   = lat_dt;
      end
      S_RESP: begin
        rvalid0 = ~owner;
        rvalid1 = owner;
      end
      default: begin
        gnt0 = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=3) in front of
// a small word memory model with registered read data and misalignment errors.
`timescale 1ns/1ps

module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- instance A (RD_LAT=1) ----------------
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
  mem_dt_e dt0 = MEM_DT_WORD, dt1 = MEM_DT_WORD;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [31:0] rd0, rd1, mem_addr, mem_wd, mem_rd;
  errno_e err0, err1, mem_err;
  mem_dt_e mem_dt;
  logic [1:0] dbg_state;

  dmem_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1), .dt0(dt0), .dt1(dt1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rd0(rd0), .rd1(rd1), .err0(err0), .err1(err1),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_dt(mem_dt),
    .mem_rd(mem_rd), .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // ---------------- instance B (RD_LAT=3), port 0 only ----------------
  logic b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [31:0] b_addr0 = 0, b_addr1 = 0, b_wd0 = 0, b_wd1 = 0;
  mem_dt_e b_dt0 = MEM_DT_WORD, b_dt1 = MEM_DT_WORD;
  logic b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we;
  logic [31:0] b_rd0, b_rd1, b_mem_addr, b_mem_wd, b_mem_rd;
  errno_e b_err0, b_err1, b_mem_err;
  mem_dt_e b_mem_dt;
  logic [1:0] b_dbg_state;

  dmem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wd0(b_wd0), .wd1(b_wd1), .dt0(b_dt0), .dt1(b_dt1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rd0(b_rd0), .rd1(b_rd1), .err0(b_err0), .err1(b_err1),
    .mem_addr(b_mem_addr), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_dt(b_mem_dt),
    .mem_rd(b_mem_rd), .mem_err(b_mem_err), .dbg_state(b_dbg_state)
  );

  // ---------------- memory model ----------------
  logic [31:0] mem [0:15];
  logic [31:0] b_p1, b_p2;
  errno_e b_e1, b_e2;

  function automatic errno_e addr_err(input logic [31:0] a, input mem_dt_e d);
    if ((d == MEM_DT_WORD && a[1:0] != 2'b00) ||
        ((d == MEM_DT_HALF || d == MEM_DT_UHALF) && a[0])) return EMISALIGN;
    if (a[31:6] != 26'd0) return EBADADDR;
    return ENONE;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[1] <= 32'h0042d213;
    end else if (mem_we) begin
      mem[mem_addr[5:2]] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    mem_rd  <= mem[mem_addr[5:2]];
    mem_err <= addr_err(mem_addr, mem_dt);
  end

  always_ff @(posedge clk) begin
    b_p1      <= mem[b_mem_addr[5:2]];
    b_p2      <= b_p1;
    b_mem_rd  <= b_p2;
    b_e1      <= addr_err(b_mem_addr, b_mem_dt);
    b_e2      <= b_e1;
    b_mem_err <= b_e2;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_pulses: got %b need 00000", {gnt0, gnt1, rvalid0, rvalid1, mem_we});
    end
    n_cmp++;
    if (mem_addr !== 32'd0 || mem_wd !== 32'd0 || mem_dt !== MEM_DT_WORD) begin
      n_fail++; $display("FAIL reset_mem_bus: got addr=%h wd=%h dt=%0d need 0/0/%0d", mem_addr, mem_wd, mem_dt, MEM_DT_WORD);
    end
    n_cmp++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0 || err0 !== ENONE || err1 !== ENONE) begin
      n_fail++; $display("FAIL reset_resp: got rd0=%h rd1=%h err0=%0d err1=%0d need zeros", rd0, rd1, err0, err1);
    end
    n_cmp++;
    if (dbg_state !== ST_IDLE || b_dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d/%0d need %0d", dbg_state, b_dbg_state, ST_IDLE);
    end
    n_cmp++;
    if ({b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we} !== 5'b00000 || b_rd0 !== 32'd0 ||
        b_rd1 !== 32'd0 || b_err1 !== ENONE || b_mem_wd !== 32'd0) begin
      n_fail++; $display("FAIL reset_dut3: got flags=%b rd0=%h rd1=%h need all idle",
                         {b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_we}, b_rd0, b_rd1);
    end
  endtask

  task automatic test_port0_read();
    req0 = 1; we0 = 0; addr0 = 32'd4; dt0 = MEM_DT_WORD;
    step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b1000 || mem_addr !== 32'd4 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL rd0_gnt: got flags=%b addr=%h we=%b need 1000/4/0", {gnt0, gnt1, rvalid0, rvalid1}, mem_addr, mem_we);
    end
    req0 = 0;
    step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000 || mem_addr !== 32'd4) begin
      n_fail++; $display("FAIL rd0_wait: got flags=%b addr=%h need 0000/4", {gnt0, gnt1, rvalid0, rvalid1}, mem_addr);
    end
    step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0010 || rd0 !== 32'h0042d213 || err0 !== ENONE) begin
      n_fail++; $display("FAIL rd0_resp: got flags=%b rd0=%h err0=%0d need 0010/0042d213/0", {gnt0, gnt1, rvalid0, rvalid1}, rd0, err0);
    end
    step();
    n_cmp++;
    if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000 || dbg_state !== ST_IDLE || rd0 !== 32'h0042d213) begin
      n_fail++; $display("FAIL rd0_after: got flags=%b state=%0d rd0=%h need 0000/0/0042d213", {gnt0, gnt1, rvalid0, rvalid1}, dbg_state, rd0);
    end
  endtask

  task automatic test_write_then_read();
    req1 = 1; we1 = 1; addr1 = 32'd8; wd1 = 32'hf0; dt1 = MEM_DT_WORD;
    step();
    n_cmp++;
    if ({gnt0, gnt1} !== 2'b01 || mem_we !== 1'b1 || mem_wd !== 32'hf0 || mem_addr !== 32'd8) begin
      n_fail++; $display("FAIL wr1_access: got gnt=%b we=%b wd=%h addr=%h need 01/1/f0/8", {gnt0, gnt1}, mem_we, mem_wd, mem_addr);
    end
    req1 = 0; we1 = 0;
    step();
    n_cmp++;
    if (mem_we !== 1'b0 || mem_addr !== 32'd8) begin
      n_fail++; $display("FAIL wr1_wait_we: got we=%b addr=%h need 0/8", mem_we, mem_addr);
    end
    step();
    n_cmp++;
    if ({rvalid0, rvalid1} !== 2'b01 || rd1 !== 32'd0 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL wr1_resp: got rvalid=%b rd1=%h we=%b need 01/0/0", {rvalid0, rvalid1}, rd1, mem_we);
    end
    step();
    req0 = 1; we0 = 0; addr0 = 32'd8; dt0 = MEM_DT_WORD;
    step();
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rd8_gnt: got gnt0=%b need 1", gnt0);
    end
    req0 = 0;
    step();
    step();
    n_cmp++;
    if (rvalid0 !== 1'b1 || rd0 !== 32'hf0) begin
      n_fail++; $display("FAIL rd8_data: got rvalid0=%b rd0=%h need 1/f0", rvalid0, rd0);
    end
    step();
  endtask

  task automatic test_contention();
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    int g0, g1, v0, v1, bad;
    g0 = 0; g1 = 0; v0 = 0; v1 = 0; bad = 0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    rst = 0; #1; rst = 1;
    req0 = 1; we0 = 0; addr0 = 32'd4; dt0 = MEM_DT_WORD;
    req1 = 1; we1 = 0; addr1 = 32'd8; dt1 = MEM_DT_WORD;
    for (int k = 0; k < 16; k++) begin
      step();
      if (gnt0) begin got_q.push_back(1'b0); g0++; end
      if (gnt1) begin got_q.push_back(1'b1); g1++; end
      if (rvalid0) v0++;
      if (rvalid1) v1++;
      if ($countones({gnt0, gnt1, rvalid0, rvalid1}) > 1) bad++;
    end
    req0 = 0; req1 = 0;
    n_cmp++;
    if (got_q.size() != 4) begin
      n_fail++; $display("FAIL cont_count: got %0d grants need 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) begin
        n_cmp++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL cont_order[%0d]: got port %0d need port %0d", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++;
    if (g0 != 2 || g1 != 2 || v0 != 2 || v1 != 2) begin
      n_fail++; $display("FAIL cont_pulses: got g0=%0d g1=%0d v0=%0d v1=%0d need 2 each", g0, g1, v0, v1);
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++; $display("FAIL cont_exclusive: got %0d overlapping cycles need 0", bad);
    end
    n_cmp++;
    if (rd0 !== 32'h0042d213 || rd1 !== 32'hf0) begin
      n_fail++; $display("FAIL cont_data: got rd0=%h rd1=%h need 0042d213/f0", rd0, rd1);
    end
    step();
  endtask

  task automatic test_rd_lat3();
    int gnt_cyc, rv_cyc, win, addr_bad;
    gnt_cyc = -1; rv_cyc = -1; win = 0; addr_bad = 0;
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'd4; b_dt0 = MEM_DT_WORD;
    for (int k = 1; k <= 12 && rv_cyc < 0; k++) begin
      step();
      if (b_gnt0) begin gnt_cyc = k; b_req0 = 0; end
      if (b_dbg_state == ST_ACCESS || b_dbg_state == ST_WAIT) begin
        win++;
        if (b_mem_addr !== 32'd4) addr_bad++;
      end
      if (b_rvalid0) rv_cyc = k;
    end
    b_req0 = 0;
    n_cmp++;
    if (gnt_cyc != 1 || rv_cyc != 5) begin
      n_fail++; $display("FAIL lat3_timing: got gnt@%0d rvalid@%0d need 1/5", gnt_cyc, rv_cyc);
    end
    n_cmp++;
    if (win != 4 || addr_bad != 0) begin
      n_fail++; $display("FAIL lat3_addr_window: got window=%0d unstable=%0d need 4/0", win, addr_bad);
    end
    n_cmp++;
    if (b_rd0 !== 32'h0042d213 || b_err0 !== ENONE || b_gnt1 !== 1'b0 || b_rvalid1 !== 1'b0) begin
      n_fail++; $display("FAIL lat3_data: got rd0=%h err0=%0d need 0042d213/0", b_rd0, b_err0);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    int stray;
    stray = 0;
    req1 = 1; we1 = 0; addr1 = 32'd4; dt1 = MEM_DT_WORD;
    step();
    req1 = 0;
    step();
    n_cmp++;
    if (dbg_state !== ST_WAIT) begin
      n_fail++; $display("FAIL rstw_in_wait: got state=%0d need %0d", dbg_state, ST_WAIT);
    end
    rst = 0;
    #0.001;
    n_cmp++;
    if (mem_addr !== 32'd0 || mem_dt !== MEM_DT_WORD || dbg_state !== ST_IDLE ||
        {gnt0, gnt1, rvalid0, rvalid1, mem_we} !== 5'b00000) begin
      n_fail++; $display("FAIL rstw_idle: got addr=%h dt=%0d state=%0d need 0/%0d/0", mem_addr, mem_dt, dbg_state, MEM_DT_WORD);
    end
    n_cmp++;
    if (rd0 !== 32'd0 || rd1 !== 32'd0 || err0 !== ENONE || err1 !== ENONE) begin
      n_fail++; $display("FAIL rstw_resp_clear: got rd0=%h rd1=%h need 0/0", rd0, rd1);
    end
    #0.001;
    rst = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (rvalid1 || rvalid0 || gnt0 || gnt1) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_fail++; $display("FAIL rstw_no_rvalid: got %0d active cycles need 0", stray);
    end
    req0 = 1; we0 = 0; addr0 = 32'd8; dt0 = MEM_DT_WORD;
    step();
    n_cmp++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rstw_next_gnt: got gnt0=%b need 1", gnt0);
    end
    req0 = 0;
    step();
    step();
    n_cmp++;
    if (rvalid0 !== 1'b1 || rd0 !== 32'hf0 || rvalid1 !== 1'b0) begin
      n_fail++; $display("FAIL rstw_next_data: got rvalid0=%b rd0=%h need 1/f0", rvalid0, rd0);
    end
    step();
  endtask

  task automatic test_misaligned();
    req0 = 1; we0 = 0; addr0 = 32'd2; dt0 = MEM_DT_WORD;
    step();
    req0 = 0;
    step();
    step();
    n_cmp++;
    if (rvalid0 !== 1'b1 || err0 !== EMISALIGN) begin
      n_fail++; $display("FAIL misalign_err: got rvalid0=%b err0=%0d need 1/%0d", rvalid0, err0, EMISALIGN);
    end
    step();
    n_cmp++;
    if (dbg_state !== ST_IDLE || rvalid0 !== 1'b0 || err0 !== EMISALIGN) begin
      n_fail++; $display("FAIL misalign_idle: got state=%0d rvalid0=%b err0=%0d need 0/0/%0d", dbg_state, rvalid0, err0, EMISALIGN);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    step();
    step();
    test_reset();
    mem_init = 0;
    rst = 1;
    step();
    test_port0_read();
    test_write_then_read();
    test_contention();
    test_rd_lat3();
    test_reset_in_wait();
    test_misaligned();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data port of cpu_mem between two requesters: port 0 = cpu data interface, port 1 = debug/loader master used by benches and the future UART program loader.
- Registered request/grant/response handshake with a round-robin tie-break; one transaction in flight at a time.
- Sits between cpu (d_addr/d_wd/d_we/d_dt/d_rd) and cpu_mem's data side; the instruction port is untouched.

Parameters:
- RD_LAT, 1, memory read latency in cycles from address valid to mem_rd valid; legal range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0, req1  in  1 each  request from port 0 / port 1.
- we0, we1  in  1 each  write enable for the request.
- addr0, addr1  in  32 each  byte address.
- wd0, wd1  in  32 each  write data.
- dt0, dt1  in  mem_dt_e each  access size.
- gnt0, gnt1  out  1 each  one-cycle pulse: request accepted.
- rvalid0, rvalid1  out  1 each  one-cycle pulse: transaction complete.
- rd0, rd1  out  32 each  read data; valid while rvalidN is high.
- err0, err1  out  errno_e each  completion status; valid while rvalidN is high.
- mem_addr  out  32  to cpu_mem d_addr.
- mem_wd  out  32  to cpu_mem d_wd.
- mem_we  out  1  to cpu_mem d_we.
- mem_dt  out  mem_dt_e  to cpu_mem d_dt.
- mem_rd  in  32  from cpu_mem d_rd.
- mem_err  in  errno_e  from cpu_mem err.

Behaviour:
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Sample req0/req1 on each rising edge.
  - If any request is high: latch the owner and its we/addr/wd/dt, then go to ACCESS.
  - Only one request high: that port wins.
  - Both high: the port that is not last_owner wins.
- ACCESS, 1 cycle:
  - gnt[owner]=1.
  - mem_* driven from the latched fields; mem_we=latched we, asserted in this cycle only, so a write commits at the closing edge.
  - Next state WAIT; wait counter loaded with RD_LAT.
- WAIT:
  - mem_addr/mem_dt are held from the latch; mem_we=0.
  - The counter decrements each cycle.
  - On the edge where the counter reaches 0: capture mem_rd (forced to 0 for writes) and mem_err into rd[owner]/err[owner], update last_owner, go to RESP.
- RESP, 1 cycle:
  - rvalid[owner]=1.
  - rd/err hold their captured values until the next capture for that port.
  - Next state IDLE.
- Latency:
  - req sampled at edge N → gnt during cycle N+1 → rvalid during cycle N+2+RD_LAT.
  - Throughput is one transaction per RD_LAT+3 cycles.
- Requester rules:
  - Hold req and all fields stable until gnt; fields are don't-care after gnt.
  - A req still high in the cycle after RESP is treated as a new request.
- Fairness: a port with req held continuously is served within 2 transactions. A continuously requesting port never wins two consecutive ties.
- Idle outputs (IDLE, RESP and reset): mem_we=0, mem_addr=0, mem_wd=0, mem_dt=MEM_DT_WORD, all gnt/rvalid=0.
- Reset (rst low, asynchronous):
  - All outputs take the idle values immediately; rd0/rd1=0; err0/err1=ENONE.
  - State → IDLE; last_owner=1, so port 0 wins the first tie.
  - Reset in ACCESS drops mem_we at once, so the write may not commit.
  - Any in-flight transaction is discarded and no rvalid is produced after reset is released.
- Errors: mem_err is passed through unmodified (e.g. misaligned access). The arbiter never retries.
- At most one gnt and one rvalid is high in any cycle; gnt and rvalid are never high in the same cycle.

Test Plan:
- Port 0 read, RD_LAT=1, cpu_mem word 1 preset to 32'h0042d213; req0 with addr0=4, dt0=word, sampled at edge N → gnt0 in cycle N+1, rvalid0 in cycle N+3, rd0=32'h0042d213, err0=ENONE; gnt1/rvalid1 stay 0.
- Port 1 write then port 0 read: port 1 writes 32'hf0 to addr 8; port 0 then reads addr 8 → rd0=32'hf0; during the write's ACCESS cycle mem_we=1 for exactly one cycle.
- Contention: req0 and req1 held high after reset for 4 transactions → grant order 0,1,0,1; each port sees exactly 2 gnt and 2 rvalid pulses.
- RD_LAT=3: a single read shows gnt→rvalid spacing of 4 cycles; mem_addr is stable for the full ACCESS+WAIT window.
- Reset pulse (rst low for 2 ps) during WAIT of a port 1 read → outputs idle immediately; no rvalid1 after release; the next req0 is served normally.
- Misaligned word read at addr 2, with cpu_mem returning an error → rvalid0 pulses with err0 equal to mem_err (not ENONE), and the FSM returns to IDLE.
